tx_arbiter: RTL and testbench

Shares the single serial TX link between the instruction scheduler and the instruction prefetcher. Each message is serialized NSHIFT bits per cycle as a one-cycle command header followed by a payload. Payload data is pulled from the granted requester one chunk per cycle. The block sits between both requesters and the `tx_pins` output. It honours the scheduler's `reserve_tx` lock so that no prefetch can slip between a scheduler read and its dependent write.

---
 rtl/tx_arbiter_pkg.sv | 22 ++
 rtl/tx_grant.sv | 28 ++
 rtl/tx_arbiter.sv | 114 +++++++++++
 tb/tb_tx_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared link constants, command headers and arbiter state encoding for the
// serial TX arbiter.
package tx_arbiter_pkg;

  localparam int TX_CMD_BITS = 2;

  // Zero is the idle value on the link, so no command header may use it.
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 2'd1;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 2'd2;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 2'd3;

  typedef enum logic [1:0] {
    TX_ARB_IDLE    = 2'd0,
    TX_ARB_HEADER  = 2'd1,
    TX_ARB_PAYLOAD = 2'd2
  } tx_arb_state_t;

  function automatic logic is_half_length(input logic [TX_CMD_BITS-1:0] cmd);
    return cmd == TX_HEADER_WRITE_8;
  endfunction

endpackage

// File: rtl/tx_grant.sv
// Combinational grant select between scheduler and prefetcher.
// With TX_ARB_ALTERNATE_EN defined, contested grants alternate after a scheduler win.
module tx_grant (
  input  logic sched_valid,
  input  logic pf_valid,
  input  logic reserve_tx,
`ifdef TX_ARB_ALTERNATE_EN
  input  logic last_sched,
`endif
  output logic grant_sched,
  output logic grant_pf
);

  always_comb begin
    grant_sched = 1'b0;
    grant_pf    = 1'b0;
`ifdef TX_ARB_ALTERNATE_EN
    if (sched_valid && pf_valid && !reserve_tx && last_sched)
      grant_pf = 1'b1;
    else
`endif
    if (sched_valid)
      grant_sched = 1'b1;
    else if (pf_valid && !reserve_tx)
      grant_pf = 1'b1;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Serial TX link arbiter: grant in IDLE, one header cycle, then N payload cycles.
// Optional alternation between requesters is enabled by TX_ARB_ALTERNATE_EN.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  localparam int CW            = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sched_valid,
  input  logic [TX_CMD_BITS-1:0] sched_command,
  input  logic [NSHIFT-1:0]      sched_data,
  input  logic                   reserve_tx,
  output logic                   sched_started,
  output logic                   sched_data_next,
  input  logic                   pf_valid,
  input  logic [NSHIFT-1:0]      pf_data,
  output logic                   pf_started,
  output logic                   pf_data_next,
  output logic                   tx_active,
  output logic                   tx_owner,
  output logic [CW-1:0]          tx_counter,
  output logic                   tx_done,
  output logic [NSHIFT-1:0]      tx_pins,
  output tx_arb_state_t          dbg_state
);

  tx_arb_state_t          state;
  logic [TX_CMD_BITS-1:0] cmd_q;
  logic                   grant_sched;
  logic                   grant_pf;
  logic                   in_idle;
  logic                   in_payload;

`ifdef TX_ARB_ALTERNATE_EN
  logic last_sched;
`endif

  tx_grant u_grant (
    .sched_valid (sched_valid),
    .pf_valid    (pf_valid),
    .reserve_tx  (reserve_tx),
`ifdef TX_ARB_ALTERNATE_EN
    .last_sched  (last_sched),
`endif
    .grant_sched (grant_sched),
    .grant_pf    (grant_pf)
  );

  assign in_idle    = (state == TX_ARB_IDLE);
  assign in_payload = (state == TX_ARB_PAYLOAD);

  // Grants are only honoured in IDLE and never while reset is held.
  assign sched_started   = in_idle && !reset && grant_sched;
  assign pf_started      = in_idle && !reset && grant_pf;
  assign sched_data_next = in_payload && tx_owner;
  assign pf_data_next    = in_payload && !tx_owner;
  assign tx_active       = !in_idle;
  assign tx_done         = in_payload && !reset && (tx_counter == CW'(1));
  assign dbg_state       = state;

  always_comb begin
    tx_pins = '0;
    case (state)
      TX_ARB_HEADER:  tx_pins = NSHIFT'(cmd_q);
      TX_ARB_PAYLOAD: tx_pins = tx_owner ? sched_data : pf_data;
      default:        tx_pins = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TX_ARB_IDLE;
      cmd_q      <= '0;
      tx_owner   <= 1'b0;
      tx_counter <= '0;
`ifdef TX_ARB_ALTERNATE_EN
      last_sched <= 1'b0;
`endif
    end else begin
      case (state)
        TX_ARB_IDLE: begin
          if (grant_sched || grant_pf) begin
            state    <= TX_ARB_HEADER;
            tx_owner <= grant_sched;
            cmd_q    <= grant_sched ? sched_command : TX_HEADER_READ_16;
`ifdef TX_ARB_ALTERNATE_EN
            last_sched <= grant_sched;
`endif
          end
        end
        TX_ARB_HEADER: begin
          // An invalid (zero) command falls through to the full length.
          tx_counter <= is_half_length(cmd_q) ? CW'(PAYLOAD_CYCLES / 2)
                                              : CW'(PAYLOAD_CYCLES);
          state      <= TX_ARB_PAYLOAD;
        end
        TX_ARB_PAYLOAD: begin
          tx_counter <= tx_counter - CW'(1);
          if (tx_counter == CW'(1))
            state <= TX_ARB_IDLE;
        end
        default: state <= TX_ARB_IDLE;
      endcase
    end
  end

  a_sched_cmd_nonzero : assert property (
    @(posedge clk) disable iff (reset) sched_started |-> (sched_command != '0)
  );

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: single grants, priority, reserve lock, WRITE_8
// length, mid-message reset and contested grant order (alternating or fixed).
module tb_tx_arbiter;
  import tx_arbiter_pkg::*;

  localparam int NSHIFT = 2;
  localparam int PC     = 8;
  localparam int CW     = $clog2(PC) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sched_valid = 1'b0;
  logic [1:0]        sched_command = '0;
  logic [NSHIFT-1:0] sched_data = '0;
  logic              reserve_tx = 1'b0;
  logic              sched_started;
  logic              sched_data_next;
  logic              pf_valid = 1'b0;
  logic [NSHIFT-1:0] pf_data = '0;
  logic              pf_started;
  logic              pf_data_next;
  logic              tx_active;
  logic              tx_owner;
  logic [CW-1:0]     tx_counter;
  logic              tx_done;
  logic [NSHIFT-1:0] tx_pins;
  tx_arb_state_t     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  tx_arbiter #(.NSHIFT(NSHIFT), .PAYLOAD_CYCLES(PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .sched_valid     (sched_valid),
    .sched_command   (sched_command),
    .sched_data      (sched_data),
    .reserve_tx      (reserve_tx),
    .sched_started   (sched_started),
    .sched_data_next (sched_data_next),
    .pf_valid        (pf_valid),
    .pf_data         (pf_data),
    .pf_started      (pf_started),
    .pf_data_next    (pf_data_next),
    .tx_active       (tx_active),
    .tx_owner        (tx_owner),
    .tx_counter      (tx_counter),
    .tx_done         (tx_done),
    .tx_pins         (tx_pins),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Follows a granted message from its header through the return to IDLE.
  task automatic expect_msg(input logic own, input logic [1:0] cmd, input int len,
                            input logic [1:0] data, input bit drop);
    @(negedge clk);
    if (drop) begin
      if (own) sched_valid = 1'b0;
      else     pf_valid    = 1'b0;
    end
    #1;
    check("hdr_pins", tx_pins, cmd);
    check("hdr_active", tx_active, 1);
    check("hdr_owner", tx_owner, own);
    check("hdr_started", sched_started | pf_started, 0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk); #1;
      check("pl_pins", tx_pins, data);
      check("pl_next_own", own ? sched_data_next : pf_data_next, 1);
      check("pl_next_other", own ? pf_data_next : sched_data_next, 0);
      check("pl_counter", tx_counter, len - i);
      check("pl_done", tx_done, (i == len - 1));
      check("pl_started", sched_started | pf_started, 0);
    end
    @(negedge clk); #1;
    check("end_active", tx_active, 0);
    check("end_pins", tx_pins, 0);
    check("end_done", tx_done, 0);
    check("end_state", dbg_state, TX_ARB_IDLE);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, TX_ARB_IDLE);
    check("rst_pins", tx_pins, 0);
    check("rst_counter", tx_counter, 0);
    check("rst_owner", tx_owner, 0);
    check("rst_active", tx_active, 0);
    check("rst_done", tx_done, 0);
    check("rst_started", sched_started | pf_started, 0);

    // single prefetch READ_16
    @(negedge clk);
    reset = 1'b0; pf_valid = 1'b1; pf_data = 2'b01;
    #1;
    check("pf_started", pf_started, 1);
    check("pf_sched_started", sched_started, 0);
    check("pf_grant_pins", tx_pins, 0);
    expect_msg(1'b0, TX_HEADER_READ_16, PC, 2'b01, 1'b1);

    // simultaneous requests: scheduler first, prefetch right after
    @(negedge clk);
    sched_valid = 1'b1; sched_command = TX_HEADER_WRITE_16; sched_data = 2'b11;
    pf_valid = 1'b1;
    #1;
    check("both_sched_started", sched_started, 1);
    check("both_pf_started", pf_started, 0);
    expect_msg(1'b1, TX_HEADER_WRITE_16, PC, 2'b11, 1'b1);
    check("after_pf_started", pf_started, 1);
    check("after_sched_started", sched_started, 0);
    expect_msg(1'b0, TX_HEADER_READ_16, PC, 2'b01, 1'b1);

    // scheduler WRITE_8 while reserve_tx is held
    @(negedge clk);
    reserve_tx = 1'b1; sched_valid = 1'b1; sched_command = TX_HEADER_WRITE_8;
    #1;
    check("w8_started", sched_started, 1);
    expect_msg(1'b1, TX_HEADER_WRITE_8, PC / 2, 2'b11, 1'b1);

    // reset in the 3rd payload cycle, pending request re-granted
    @(negedge clk);
    reserve_tx = 1'b0; sched_valid = 1'b1; sched_command = TX_HEADER_WRITE_16;
    #1;
    check("mr_started", sched_started, 1);
    @(negedge clk); #1;
    check("mr_hdr", tx_pins, TX_HEADER_WRITE_16);
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr_pl3_counter", tx_counter, PC - 2);
    check("mr_pl3_done", tx_done, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_state", dbg_state, TX_ARB_IDLE);
    check("mr_pins", tx_pins, 0);
    check("mr_counter", tx_counter, 0);
    check("mr_done", tx_done, 0);
    check("mr_regrant", sched_started, 1);
    expect_msg(1'b1, TX_HEADER_WRITE_16, PC, 2'b11, 1'b1);

    // reserve_tx blocks the prefetcher until released
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        reserve_tx = 1'b1; pf_valid = 1'b1;
      end
      #1;
      check("rsv_pf_started", pf_started, 0);
      check("rsv_active", tx_active, 0);
    end
    @(negedge clk);
    reserve_tx = 1'b0;
    #1;
    check("rsv_release", pf_started, 1);
    expect_msg(1'b0, TX_HEADER_READ_16, PC, 2'b01, 1'b1);

    // both requesting continuously for four messages
`ifdef TX_ARB_ALTERNATE_EN
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    @(negedge clk);
    sched_valid = 1'b1; pf_valid = 1'b1; sched_command = TX_HEADER_WRITE_16;
    #1;
    while (exp_q.size() > 0) begin
      logic [0:0] own;
      own = exp_q.pop_front();
      check("seq_sched_started", sched_started, own);
      check("seq_pf_started", pf_started, !own);
      @(negedge clk); #1;
      check("seq_owner", tx_owner, own);
      check("seq_hdr", tx_pins, own ? TX_HEADER_WRITE_16 : TX_HEADER_READ_16);
      repeat (PC) @(negedge clk);
      @(negedge clk); #1;
      check("seq_idle", tx_active, 0);
    end
    sched_valid = 1'b0; pf_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
